// File: rtl/life_grid_pkg.sv
// life_grid_pkg: shared types and Game-of-Life rule for the grid engine.
//   state_t       engine FSM states (IDLE / COMPUTE / COMMIT)
//   count_t       4-bit live-neighbour count
//   BIRTH_COUNT, SURVIVE_LO, SURVIVE_HI  B3/S23 rule constants
//   cell_next()   next state of one cell from its state and neighbour count
package life_grid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } state_t;

  typedef logic [3:0] count_t;

  localparam count_t BIRTH_COUNT = 4'd3;
  localparam count_t SURVIVE_LO  = 4'd2;
  localparam count_t SURVIVE_HI  = 4'd3;

  function automatic logic cell_next(input logic alive, input count_t count);
    return (count == BIRTH_COUNT) ||
           (alive && (count >= SURVIVE_LO) && (count <= SURVIVE_HI));
  endfunction

endpackage

// File: rtl/life_row_update.sv
// life_row_update: combinational next-generation computation of one grid row.
//   i_row_above  row above the one being updated (already edge-resolved by caller)
//   i_row_cur    row being updated
//   i_row_below  row below the one being updated (already edge-resolved by caller)
//   o_row_next   next-generation value of i_row_cur
// Horizontal edge policy: macro LIFE_GRID_TORUS_WRAP_EN wraps column -1 / GRID_WIDTH
// around the row; otherwise cells beyond the row ends read as dead.
module life_row_update
  import life_grid_pkg::*;
#(
  parameter int GRID_WIDTH = 8
) (
  input  logic [GRID_WIDTH-1:0] i_row_above,
  input  logic [GRID_WIDTH-1:0] i_row_cur,
  input  logic [GRID_WIDTH-1:0] i_row_below,
  output logic [GRID_WIDTH-1:0] o_row_next
);

  // Rows padded by one column on each side: ext[0] is column -1, ext[x+1] is column x.
  logic [GRID_WIDTH+1:0] w_above_ext;
  logic [GRID_WIDTH+1:0] w_cur_ext;
  logic [GRID_WIDTH+1:0] w_below_ext;
  count_t                w_cnt;

  always_comb begin
`ifdef LIFE_GRID_TORUS_WRAP_EN
    w_above_ext = {i_row_above[0], i_row_above, i_row_above[GRID_WIDTH-1]};
    w_cur_ext   = {i_row_cur[0],   i_row_cur,   i_row_cur[GRID_WIDTH-1]};
    w_below_ext = {i_row_below[0], i_row_below, i_row_below[GRID_WIDTH-1]};
`else
    w_above_ext = {1'b0, i_row_above, 1'b0};
    w_cur_ext   = {1'b0, i_row_cur,   1'b0};
    w_below_ext = {1'b0, i_row_below, 1'b0};
`endif
  end

  always_comb begin
    o_row_next = '0;
    w_cnt      = '0;
    for (int unsigned x = 0; x < GRID_WIDTH; x++) begin
      w_cnt = count_t'(w_above_ext[x]) + count_t'(w_above_ext[x+1]) + count_t'(w_above_ext[x+2]) +
              count_t'(w_cur_ext[x])                                 + count_t'(w_cur_ext[x+2])   +
              count_t'(w_below_ext[x]) + count_t'(w_below_ext[x+1]) + count_t'(w_below_ext[x+2]);
      o_row_next[x] = cell_next(i_row_cur[x], w_cnt);
    end
  end

endmodule

// File: rtl/life_grid_engine.sv
// life_grid_engine: sequential Game-of-Life engine. Computes one row per clock
// into a shadow buffer and commits each whole generation in a single cycle.
//   clk, reset              clock, asynchronous active-high reset
//   load_valid/load_ready   load handshake; load_state bit GRID_WIDTH*y+x
//   run_valid/run_ready     run handshake; run_count generations to advance
//   busy                    run in progress
//   done                    one-cycle pulse at end of run (or after a zero-length run)
//   grid_state              committed grid
//   generation              generations since last load (wraps)
//   stable                  last committed generation equalled its predecessor
//   extinct                 grid_state is all zero
// Macro LIFE_GRID_TORUS_WRAP_EN selects toroidal edges (vertical here, horizontal
// inside life_row_update); undefined gives a bounded plane.
module life_grid_engine
  import life_grid_pkg::*;
#(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] load_state,
  input  logic                              run_valid,
  output logic                              run_ready,
  input  logic [GEN_WIDTH-1:0]              run_count,
  output logic                              busy,
  output logic                              done,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] grid_state,
  output logic [GEN_WIDTH-1:0]              generation,
  output logic                              stable,
  output logic                              extinct
);

  localparam int                   CELLS    = GRID_WIDTH * GRID_HEIGHT;
  localparam int                   ROW_W    = $clog2(GRID_HEIGHT);
  localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(GRID_HEIGHT - 1);
  localparam logic [ROW_W-1:0]     ROW_ONE  = ROW_W'(1);
  localparam logic [GEN_WIDTH-1:0] GEN_ONE  = GEN_WIDTH'(1);

  state_t                r_state;
  logic [CELLS-1:0]      r_grid;
  logic [GEN_WIDTH-1:0]  r_gen;
  logic [GEN_WIDTH-1:0]  r_remaining;
  logic [ROW_W-1:0]      r_row;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_stable;
  logic [GRID_WIDTH-1:0] r_shadow [GRID_HEIGHT];

  logic [GRID_WIDTH-1:0] w_rows [GRID_HEIGHT];
  logic [GRID_WIDTH-1:0] w_above;
  logic [GRID_WIDTH-1:0] w_cur;
  logic [GRID_WIDTH-1:0] w_below;
  logic [GRID_WIDTH-1:0] w_next_row;
  logic [CELLS-1:0]      w_shadow_flat;
  logic                  w_load_hs;
  logic                  w_run_hs;
  logic                  w_same;
  logic                  w_empty;
  logic                  w_last_gen;

  always_comb begin
    w_rows        = '{default: '0};
    w_shadow_flat = '0;
    for (int unsigned y = 0; y < GRID_HEIGHT; y++) begin
      w_rows[y]                                    = r_grid[y*GRID_WIDTH +: GRID_WIDTH];
      w_shadow_flat[y*GRID_WIDTH +: GRID_WIDTH]    = r_shadow[y];
    end
  end

  // Vertical neighbour rows for the row currently being computed.
  always_comb begin
    w_cur = w_rows[r_row];
    if (r_row == '0) begin
`ifdef LIFE_GRID_TORUS_WRAP_EN
      w_above = w_rows[GRID_HEIGHT-1];
`else
      w_above = '0;
`endif
    end else begin
      w_above = w_rows[r_row - ROW_ONE];
    end
    if (r_row == LAST_ROW) begin
`ifdef LIFE_GRID_TORUS_WRAP_EN
      w_below = w_rows[0];
`else
      w_below = '0;
`endif
    end else begin
      w_below = w_rows[r_row + ROW_ONE];
    end
  end

  life_row_update #(
    .GRID_WIDTH(GRID_WIDTH)
  ) u_row_update (
    .i_row_above(w_above),
    .i_row_cur  (w_cur),
    .i_row_below(w_below),
    .o_row_next (w_next_row)
  );

  assign load_ready = (r_state == IDLE);
  // A pending load wins; the run requester keeps run_valid high until accepted.
  assign run_ready  = (r_state == IDLE) && !load_valid;
  assign w_load_hs  = load_valid && load_ready;
  assign w_run_hs   = run_valid && run_ready;

  assign w_same     = (w_shadow_flat == r_grid);
  assign w_empty    = (w_shadow_flat == '0);
  assign w_last_gen = (r_remaining == GEN_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grid      <= '0;
      r_gen       <= '0;
      r_remaining <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stable    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_load_hs) begin
            r_grid   <= load_state;
            r_gen    <= '0;
            r_stable <= 1'b0;
          end else if (w_run_hs) begin
            if (run_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_remaining <= run_count;
              r_row       <= '0;
              r_busy      <= 1'b1;
              r_state     <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (r_row == LAST_ROW) begin
            r_state <= COMMIT;
          end else begin
            r_row <= r_row + ROW_ONE;
          end
        end
        COMMIT: begin
          r_grid      <= w_shadow_flat;
          r_gen       <= r_gen + GEN_ONE;
          r_stable    <= w_same;
          r_remaining <= r_remaining - GEN_ONE;
          if (w_last_gen || w_same || w_empty) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= COMPUTE;
            r_row   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Shadow rows are fully rewritten before every commit, so no reset is needed.
  always_ff @(posedge clk) begin
    if (r_state == COMPUTE) begin
      r_shadow[r_row] <= w_next_row;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign grid_state = r_grid;
  assign generation = r_gen;
  assign stable     = r_stable;
  assign extinct    = (r_grid == '0);

endmodule

// File: tb/tb_life_grid_engine.sv
module tb_life_grid_engine;

  localparam int W       = 8;
  localparam int H       = 8;
  localparam int N       = W * H;
  localparam int GW      = 16;
  localparam int GEN_LAT = H + 1;

  localparam logic [N-1:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [N-1:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [N-1:0] BLOCK   = 64'h0000_0000_0006_0600;
  localparam logic [N-1:0] SINGLE  = 64'h0000_0010_0000_0000;
  localparam logic [N-1:0] GLIDER  = 64'h0000_0000_0007_0402;
  localparam logic [N-1:0] GLIDER4 = 64'h0000_0000_0E08_0400;
  localparam logic [N-1:0] GLIDER_BR = 64'hE080_4000_0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic          run_valid = 1'b0;
  logic [N-1:0]  load_state = '0;
  logic [GW-1:0] run_count = '0;
  logic          load_ready, run_ready, busy, done, stable, extinct;
  logic [N-1:0]  grid_state;
  logic [GW-1:0] generation;

  always #5 clk = ~clk;

  life_grid_engine #(
    .GRID_WIDTH (W),
    .GRID_HEIGHT(H),
    .GEN_WIDTH  (GW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_state(load_state),
    .run_valid (run_valid),
    .run_ready (run_ready),
    .run_count (run_count),
    .busy      (busy),
    .done      (done),
    .grid_state(grid_state),
    .generation(generation),
    .stable    (stable),
    .extinct   (extinct)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [N-1:0] life_step(input logic [N-1:0] g);
    logic [N-1:0] r;
    r = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int c;
        c = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx != 0 || dy != 0) begin
              int nx;
              int ny;
              nx = x + dx;
              ny = y + dy;
`ifdef LIFE_GRID_TORUS_WRAP_EN
              nx = (nx + W) % W;
              ny = (ny + H) % H;
              c += int'(g[ny*W+nx]);
`else
              if (nx >= 0 && nx < W && ny >= 0 && ny < H) c += int'(g[ny*W+nx]);
`endif
            end
          end
        end
        r[y*W+x] = (c == 3) || (g[y*W+x] && c == 2);
      end
    end
    return r;
  endfunction

  logic [N-1:0]  m_grid;
  logic [GW-1:0] m_gen;
  logic [GW-1:0] m_base;
  logic          m_stable;
  logic          m_done;
  logic          m_active;
  int            m_edges;
  int            m_k;
  logic [N-1:0]  m_sched[$];

  task automatic model_reset();
    m_grid   = '0;
    m_gen    = '0;
    m_base   = '0;
    m_stable = 1'b0;
    m_done   = 1'b0;
    m_active = 1'b0;
    m_edges  = 0;
    m_k      = 0;
    m_sched.delete();
  endtask

  // Whole run precomputed as a list of generations; timing is pure arithmetic
  // on the number of clock edges since the run was accepted.
  task automatic model_edge();
    int j;
    logic [N-1:0] nxt;
    m_done = 1'b0;
    if (reset) begin
      model_reset();
    end else if (m_active) begin
      m_edges++;
      j = m_edges / GEN_LAT;
      if (j > m_k) j = m_k;
      m_grid = m_sched[j];
      m_gen  = m_base + GW'(j);
      if (j >= 1) m_stable = (m_sched[j] == m_sched[j-1]);
      if (m_edges == m_k * GEN_LAT) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (load_valid) begin
      m_grid   = load_state;
      m_gen    = '0;
      m_stable = 1'b0;
    end else if (run_valid) begin
      if (run_count == '0) begin
        m_done = 1'b1;
      end else begin
        m_sched.delete();
        m_sched.push_back(m_grid);
        m_k = 0;
        for (int i = 1; i <= int'(run_count); i++) begin
          nxt = life_step(m_sched[i-1]);
          m_sched.push_back(nxt);
          m_k = i;
          if (nxt == m_sched[i-1] || nxt == '0) break;
        end
        m_base   = m_gen;
        m_edges  = 0;
        m_active = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("grid_state", grid_state, m_grid);
      chk("generation", N'(generation), N'(m_gen));
      chk("stable", N'(stable), N'(m_stable));
      chk("extinct", N'(extinct), N'(m_grid == '0));
      chk("busy", N'(busy), N'(m_active));
      chk("done", N'(done), N'(m_done));
      chk("load_ready", N'(load_ready), N'(!m_active));
      chk("run_ready", N'(run_ready), N'(!m_active && !load_valid));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic do_load(input logic [N-1:0] v);
    load_valid = 1'b1;
    load_state = v;
    cycle();
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = done;
    while (!seen && lat < 4000) begin
      cycle();
      lat++;
      seen = done;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no done, expected done within 4000 cycles", nm);
    end
    chk({nm, "_latency"}, N'(lat), N'(exp_lat));
  endtask

  task automatic do_run(input string nm, input int n, input int exp_lat);
    run_valid = 1'b1;
    run_count = GW'(n);
    cycle();
    run_valid = 1'b0;
    wait_done(nm, exp_lat);
  endtask

  initial begin
    int n_done;
    model_reset();
    chk_on = 1'b1;
    #1 reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    #1;
    chk("rst_extinct", N'(extinct), N'(1));
    chk("rst_grid", grid_state, '0);

    // Blinker
    do_load(BLINK_H);
    do_run("blink1", 1, GEN_LAT);
    chk("blink1_grid", grid_state, BLINK_V);
    chk("blink1_gen", N'(generation), N'(1));
    chk("blink1_stable", N'(stable), N'(0));
    do_run("blink2", 2, 2 * GEN_LAT);
    chk("blink2_grid", grid_state, BLINK_V);
    chk("blink2_gen", N'(generation), N'(3));

    // Still life stops after one generation
    do_load(BLOCK);
    do_run("block", 100, GEN_LAT);
    chk("block_grid", grid_state, BLOCK);
    chk("block_gen", N'(generation), N'(1));
    chk("block_stable", N'(stable), N'(1));

    // Extinction stops after one generation
    do_load(SINGLE);
    do_run("single", 5, GEN_LAT);
    chk("single_grid", grid_state, '0);
    chk("single_extinct", N'(extinct), N'(1));
    chk("single_gen", N'(generation), N'(1));

    // Zero-length run
    do_run("zero", 0, 0);
    chk("zero_gen", N'(generation), N'(1));

    // Load and run requested together: load first, run next cycle
    load_valid = 1'b1;
    load_state = GLIDER;
    run_valid  = 1'b1;
    run_count  = GW'(4);
    #1;
    chk("prio_run_ready", N'(run_ready), N'(0));
    chk("prio_load_ready", N'(load_ready), N'(1));
    cycle();
    load_valid = 1'b0;
    chk("prio_loaded", grid_state, GLIDER);
    cycle();
    run_valid = 1'b0;
    chk("prio_busy", N'(busy), N'(1));
    wait_done("glider", 4 * GEN_LAT);
    chk("glider_grid", grid_state, GLIDER4);
    chk("glider_gen", N'(generation), N'(4));

    // Glider at bottom-right: wraps or gets clipped depending on edge policy
    do_load(GLIDER_BR);
    run_valid = 1'b1;
    run_count = GW'(12);
    cycle();
    run_valid = 1'b0;
    wait_done("edge", m_k * GEN_LAT);
    chk("edge_grid", grid_state, m_sched[m_k]);

    // Reset during generation 2 of a 10-generation run
    do_load(GLIDER);
    run_valid = 1'b1;
    run_count = GW'(10);
    cycle();
    run_valid = 1'b0;
    repeat (GEN_LAT + 3) cycle();
    chk("pre_rst_busy", N'(busy), N'(1));
    reset = 1'b1;
    #1;
    chk("arst_busy", N'(busy), N'(0));
    chk("arst_done", N'(done), N'(0));
    chk("arst_grid", grid_state, '0);
    chk("arst_gen", N'(generation), N'(0));
    chk("arst_stable", N'(stable), N'(0));
    chk("arst_load_ready", N'(load_ready), N'(1));
    chk("arst_extinct", N'(extinct), N'(1));
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    n_done = 0;
    repeat (3 * GEN_LAT) begin
      cycle();
      if (done) n_done++;
    end
    chk("post_rst_no_done", N'(n_done), N'(0));
    chk("post_rst_load_ready", N'(load_ready), N'(1));

    repeat (2) cycle();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
